// File: rtl/uart_wbm_pkg.sv
// Shared types for the UART Wishbone register-access master.
// Holds the FSM state encoding, the queued command record and the lane-select helper.
// Timeout counter width lives here so the FSM and any future users agree on it.
package uart_wbm_pkg;

  localparam int TMO_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] addr;
    logic       we;
    logic [7:0] wdata;
  } uart_wbm_cmd_t;

  // One-hot byte lane for a byte address on the 32-bit bus.
  function automatic logic [3:0] lane_sel(input logic [1:0] addr);
    return 4'b0001 << addr;
  endfunction

endpackage

// File: rtl/uart_wb_master_if.sv
// Bundles for the command/response side and the Wishbone side of uart_wb_master.
// uart_wb_master_if: master = controller issuing commands, slave = the bus master block.
// uart_wbm_wb_if: master = the bus master block, slave = the UART 16550 register port.
interface uart_wb_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_addr;
  logic       cmd_we;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_we, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_we, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface uart_wbm_wb_if;
  logic [4:0]  wbm_addr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_stb_o;
  logic        wbm_cyc_o;
  logic        wbm_ack_i;

  modport master (
    output wbm_addr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_addr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_stb_o, wbm_cyc_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/uart_wbm_fifo.sv
// Synchronous command FIFO of uart_wbm_cmd_t, DEPTH a power of two >= 2.
// Read data is the head entry combinationally; push and pop take effect on the clock edge.
// Push is ignored when full and pop when empty; simultaneous push/pop keeps the count.
module uart_wbm_fifo
  import uart_wbm_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  uart_wbm_cmd_t wdata,
  output uart_wbm_cmd_t rdata,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  uart_wbm_cmd_t mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/uart_wb_master.sv
// Wishbone classic single-access master for the UART 16550 register port; optional UART_WBM_TIMEOUT_EN.
// Latency: push to cyc/stb is 2 edges; zero-wait ack gives rsp_valid 1 edge after cyc rises (3-cycle min).
// Backpressure: cmd_ready = FIFO not full; response held in RESP until rsp_ready, stalling further pops.
module uart_wb_master
  import uart_wbm_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  uart_wb_master_if.slave   cmd,
  uart_wbm_wb_if.master     wb,
  output logic              busy
);

  uart_wbm_cmd_t push_dat;
  uart_wbm_cmd_t head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  state_t        state;
  logic [7:0]    rd_lane;

  assign push_dat      = '{addr: cmd.cmd_addr, we: cmd.cmd_we, wdata: cmd.cmd_wdata};
  assign cmd.cmd_ready = !fifo_full;
  // Pop only from IDLE; the FIFO output is registered into the bus fields on that edge.
  assign pop           = (state == IDLE) && !fifo_empty;
  assign busy          = !fifo_empty || (state != IDLE);
  assign rd_lane       = wb.wbm_dat_i[{wb.wbm_addr_o[1:0], 3'b000} +: 8];

  uart_wbm_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (cmd.cmd_valid),
    .pop   (pop),
    .wdata (push_dat),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef UART_WBM_TIMEOUT_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;
  assign cmd.rsp_err = err_q;
`else
  assign cmd.rsp_err = 1'b0;
`endif

  // Command sequencer: IDLE pops and launches, BUS waits for ack (or timeout), RESP holds the result.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      wb.wbm_addr_o <= '0;
      wb.wbm_dat_o  <= '0;
      wb.wbm_sel_o  <= '0;
      wb.wbm_we_o   <= 1'b0;
      wb.wbm_stb_o  <= 1'b0;
      wb.wbm_cyc_o  <= 1'b0;
      cmd.rsp_valid <= 1'b0;
      cmd.rsp_rdata <= '0;
`ifdef UART_WBM_TIMEOUT_EN
      tmo_cnt       <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            wb.wbm_addr_o <= head.addr;
            wb.wbm_we_o   <= head.we;
            wb.wbm_sel_o  <= lane_sel(head.addr[1:0]);
            wb.wbm_dat_o  <= {4{head.wdata}};
            wb.wbm_cyc_o  <= 1'b1;
            wb.wbm_stb_o  <= 1'b1;
`ifdef UART_WBM_TIMEOUT_EN
            tmo_cnt       <= '0;
`endif
            state         <= BUS;
          end
        end
        BUS: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (wb.wbm_ack_i) begin
            cmd.rsp_rdata <= wb.wbm_we_o ? 8'h00 : rd_lane;
            cmd.rsp_valid <= 1'b1;
            wb.wbm_cyc_o  <= 1'b0;
            wb.wbm_stb_o  <= 1'b0;
`ifdef UART_WBM_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
            state         <= RESP;
          end
`ifdef UART_WBM_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            cmd.rsp_rdata <= 8'h00;
            cmd.rsp_valid <= 1'b1;
            err_q         <= 1'b1;
            wb.wbm_cyc_o  <= 1'b0;
            wb.wbm_stb_o  <= 1'b0;
            state         <= RESP;
          end else begin
            tmo_cnt       <= tmo_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (cmd.rsp_ready) begin
            cmd.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// Self-checking bench for uart_wb_master: table of single transactions plus
// FIFO backpressure, mid-bus reset and timeout / no-timeout sequences.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_wb_master;
  import uart_wbm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  uart_wb_master_if cif ();
  uart_wbm_wb_if    wif ();

  uart_wb_master #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd      (cif.slave),
    .wb       (wif.master),
    .busy     (busy)
  );

  int checks = 0;
  int errors = 0;

  // Wishbone slave model: ack after ack_wait wait states, data fixed or derived from address.
  bit          ack_en   = 1'b0;
  int          ack_wait = 0;
  bit          dat_auto = 1'b0;
  logic [31:0] dat_sel  = 32'h0;
  int          wcnt     = 0;

  always @(negedge clk) begin
    wif.wbm_ack_i = wif.wbm_cyc_o && ack_en && (wcnt == ack_wait);
    wif.wbm_dat_i = dat_auto ? {4{8'(wif.wbm_addr_o) ^ 8'hA0}} : dat_sel;
    if (wif.wbm_cyc_o) wcnt = wcnt + 1;
    else               wcnt = 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic        we;
    logic [7:0]  wdata;
    logic [31:0] dat_i;
    int          waits;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [6];

  // One command through an idle DUT; called on a falling edge.
  task automatic do_txn(input vec_t v);
    int n;
    ack_en   = 1'b1;
    ack_wait = v.waits;
    dat_auto = 1'b0;
    dat_sel  = v.dat_i;
    cif.cmd_valid = 1'b1;
    cif.cmd_addr  = v.addr;
    cif.cmd_we    = v.we;
    cif.cmd_wdata = v.wdata;
    check("cmd_ready_idle", cif.cmd_ready, 1);
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    check("no_bypass_cyc", wif.wbm_cyc_o, 0);
    check("busy_queued", busy, 1);
    n = 0;
    while (!wif.wbm_cyc_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pop_latency", n, 1);
    check("stb", wif.wbm_stb_o, 1);
    check("sel", wif.wbm_sel_o, v.sel);
    check("dat_o", wif.wbm_dat_o, v.dat_o);
    check("we", wif.wbm_we_o, v.we);
    check("addr", wif.wbm_addr_o, v.addr);
    check("rsp_valid_in_bus", cif.rsp_valid, 0);
    n = 0;
    while (wif.wbm_cyc_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cyc_len", n, v.waits + 1);
    check("stb_low", wif.wbm_stb_o, 0);
    check("rsp_valid", cif.rsp_valid, 1);
    check("rsp_rdata", cif.rsp_rdata, v.rdata);
    check("rsp_err", cif.rsp_err, 0);
    @(negedge clk);
    check("rsp_valid_hold", cif.rsp_valid, 1);
    check("rsp_rdata_hold", cif.rsp_rdata, v.rdata);
    check("cyc_in_resp", wif.wbm_cyc_o, 0);
    cif.rsp_ready = 1'b1;
    @(negedge clk);
    cif.rsp_ready = 1'b0;
    check("rsp_valid_clear", cif.rsp_valid, 0);
    check("busy_done", busy, 0);
  endtask

  logic [4:0] faddr [6];
  bit         exp_rdy [13];

  initial begin
    int n;
    int k;
    int nrsp;
    bit prev_v;
    bit prev_r;
    bit saw_cyc;
    bit saw_rsp;

    vecs[0] = '{addr: 5'h03, we: 1'b1, wdata: 8'h83, dat_i: 32'hDEADBEEF, waits: 0,
                sel: 4'b1000, dat_o: 32'h83838383, rdata: 8'h00};
    vecs[1] = '{addr: 5'h05, we: 1'b0, wdata: 8'h00, dat_i: 32'h00006000, waits: 2,
                sel: 4'b0010, dat_o: 32'h00000000, rdata: 8'h60};
    vecs[2] = '{addr: 5'h00, we: 1'b0, wdata: 8'h11, dat_i: 32'h123456AB, waits: 1,
                sel: 4'b0001, dat_o: 32'h11111111, rdata: 8'hAB};
    vecs[3] = '{addr: 5'h1E, we: 1'b0, wdata: 8'hC3, dat_i: 32'hA1B2C3D4, waits: 0,
                sel: 4'b0100, dat_o: 32'hC3C3C3C3, rdata: 8'hB2};
    vecs[4] = '{addr: 5'h1F, we: 1'b1, wdata: 8'h5A, dat_i: 32'hFFFFFFFF, waits: 3,
                sel: 4'b1000, dat_o: 32'h5A5A5A5A, rdata: 8'h00};
    vecs[5] = '{addr: 5'h07, we: 1'b0, wdata: 8'h3C, dat_i: 32'h99000000, waits: 0,
                sel: 4'b1000, dat_o: 32'h3C3C3C3C, rdata: 8'h99};
    faddr   = '{5'h01, 5'h06, 5'h0B, 5'h10, 5'h15, 5'h1A};
    exp_rdy = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};

    // Reset state
    rst = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_addr  = '0;
    cif.cmd_we    = 1'b0;
    cif.cmd_wdata = '0;
    cif.rsp_ready = 1'b0;
    #2;
    check("rst_cyc", wif.wbm_cyc_o, 0);
    check("rst_stb", wif.wbm_stb_o, 0);
    check("rst_we", wif.wbm_we_o, 0);
    check("rst_sel", wif.wbm_sel_o, 0);
    check("rst_dat_o", wif.wbm_dat_o, 0);
    check("rst_addr", wif.wbm_addr_o, 0);
    check("rst_rsp_valid", cif.rsp_valid, 0);
    check("rst_rsp_rdata", cif.rsp_rdata, 0);
    check("rst_rsp_err", cif.rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cif.cmd_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // FIFO fill with response backpressure, then drain in order
    ack_en = 1'b1; ack_wait = 0; dat_auto = 1'b1;
    k = 0; nrsp = 0; prev_v = 1'b0; prev_r = 1'b0;
    for (int t = 0; t < 150 && (nrsp < 6 || k < 6); t++) begin
      if (prev_v && prev_r) k++;
      if (t <= 12) check($sformatf("fifo_ready_t%0d", t), cif.cmd_ready, exp_rdy[t]);
      if (t == 12) check("fifo_5th_waits", k, 5);
      if (t == 10) cif.rsp_ready = 1'b1;
      if (cif.rsp_valid && cif.rsp_ready && nrsp < 6) begin
        check($sformatf("fifo_order_%0d", nrsp), cif.rsp_rdata, {3'b000, faddr[nrsp]} ^ 8'hA0);
        nrsp++;
      end
      cif.cmd_valid = (k < 6);
      cif.cmd_addr  = (k < 6) ? faddr[k] : 5'h00;
      cif.cmd_we    = 1'b0;
      cif.cmd_wdata = 8'h00;
      prev_v = cif.cmd_valid;
      prev_r = cif.cmd_ready;
      @(negedge clk);
    end
    cif.cmd_valid = 1'b0;
    cif.rsp_ready = 1'b0;
    dat_auto = 1'b0;
    check("fifo_accepted", k, 6);
    check("fifo_responses", nrsp, 6);
    check("fifo_busy_end", busy, 0);

    // Reset while a cycle is stalled on the bus with two commands queued
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cif.cmd_valid = 1'b1;
      cif.cmd_addr  = 5'(i + 2);
      cif.cmd_we    = 1'b1;
      cif.cmd_wdata = 8'(i);
      @(negedge clk);
    end
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    check("rstbus_cyc_before", wif.wbm_cyc_o, 1);
    check("rstbus_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rstbus_cyc_async", wif.wbm_cyc_o, 0);
    check("rstbus_stb_async", wif.wbm_stb_o, 0);
    check("rstbus_rsp_valid_async", cif.rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
    check("rstbus_busy_after", busy, 0);
    check("rstbus_ready_after", cif.cmd_ready, 1);
    saw_cyc = 1'b0; saw_rsp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (wif.wbm_cyc_o) saw_cyc = 1'b1;
      if (cif.rsp_valid) saw_rsp = 1'b1;
      @(negedge clk);
    end
    check("rstbus_no_cyc", saw_cyc, 0);
    check("rstbus_no_rsp", saw_rsp, 0);

    // No ack: timeout error, or indefinite wait when the timeout is compiled out
    ack_en = 1'b0;
    dat_sel = 32'hFFFFFFFF;
    cif.cmd_valid = 1'b1;
    cif.cmd_addr  = 5'h02;
    cif.cmd_we    = 1'b0;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    n = 0;
    while (!wif.wbm_cyc_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cyc_start", wif.wbm_cyc_o, 1);
    n = 0;
`ifdef UART_WBM_TIMEOUT_EN
    while (wif.wbm_cyc_o && n < 1100) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cyc_len", n, 255);
    check("tmo_rsp_valid", cif.rsp_valid, 1);
    check("tmo_rsp_err", cif.rsp_err, 1);
    check("tmo_rsp_rdata", cif.rsp_rdata, 0);
    cif.rsp_ready = 1'b1;
    @(negedge clk);
    cif.rsp_ready = 1'b0;
    check("tmo_rsp_clear", cif.rsp_valid, 0);
    check("tmo_busy_end", busy, 0);
`else
    while (wif.wbm_cyc_o && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("notmo_cyc_len", n, 1000);
    check("notmo_cyc_high", wif.wbm_cyc_o, 1);
    check("notmo_rsp_valid", cif.rsp_valid, 0);
    check("notmo_rsp_err", cif.rsp_err, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("notmo_busy_after_rst", busy, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
